// File: rtl/fpga_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// fpga_rst_seq_pkg
// Shared types and constants for the board-level reset sequencer.
//   rst_state_e  : sequencer state encoding, also exported on state_o for ILA
//   DEF_*        : default cycle counts (50 MHz system clock)
//   max4         : largest of four counts, sizes the shared down-counter
//   cnt_width    : bits needed to hold a count value
// -----------------------------------------------------------------------------
package fpga_rst_seq_pkg;

    typedef enum logic [2:0] {
        PERST = 3'd0,
        CALIB = 3'd1,
        PHY   = 3'd2,
        WREL  = 3'd3,
        RUN   = 3'd4,
        HOLD  = 3'd5,
        FAULT = 3'd6
    } rst_state_e;

    // 100 ms of PERST_N low at 50 MHz
    localparam int unsigned DEF_PERST_CYC = 32'd5000000;
    // 1 s budget for DDR calibration
    localparam int unsigned DEF_CALIB_TMO = 32'd50000000;
    // 10 ms between PHY release and CPU release readiness
    localparam int unsigned DEF_PHY_DLY   = 32'd500000;
    // minimum CPU reset width on a re-reset
    localparam int unsigned DEF_CPU_HOLD  = 32'd1000;
    localparam bit          DEF_AUTO_REL  = 1'b0;

    function automatic int unsigned max4(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c,
                                         input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        if (d > m) begin
            m = d;
        end
        return m;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/fpga_rst_seq_if.sv
// -----------------------------------------------------------------------------
// fpga_rst_seq_if
// Board-side signals of the reset sequencer.
//   master : board/button/DDR side, drives the requests and observes resets
//   slave  : the sequencer itself
// Signals:
//   cpu_rel_i     single-cycle CPU release pulse (debounced button)
//   cpu_hold_i    level, forces the CPU back into reset while running
//   calib_done_i  DDR init_calib_complete (asynchronous to clk)
//   perst_n_o     PCIe PERST_N
//   phy_rst_o     Ethernet PHY run enable (1 = running)
//   cpu_rstn_o    CPU core reset, active-low
//   fault_o       calibration timeout or loss
//   state_o       current sequencer state
// -----------------------------------------------------------------------------
interface fpga_rst_seq_if;

    logic       cpu_rel_i;
    logic       cpu_hold_i;
    logic       calib_done_i;
    logic       perst_n_o;
    logic       phy_rst_o;
    logic       cpu_rstn_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport master (
        output cpu_rel_i,
        output cpu_hold_i,
        output calib_done_i,
        input  perst_n_o,
        input  phy_rst_o,
        input  cpu_rstn_o,
        input  fault_o,
        input  state_o
    );

    modport slave (
        input  cpu_rel_i,
        input  cpu_hold_i,
        input  calib_done_i,
        output perst_n_o,
        output phy_rst_o,
        output cpu_rstn_o,
        output fault_o,
        output state_o
    );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer. The output follows the input two clock
// edges later. Both flops are cleared by the synchronous reset so that a
// re-sequence never sees a stale level from before the reset.
//   clk   destination clock
//   rst   synchronous active-high reset
//   din   asynchronous input
//   dout  synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE" *) logic meta_r;
    (* ASYNC_REG = "TRUE" *) logic sync_r;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/fpga_rst_seq.sv
// -----------------------------------------------------------------------------
// fpga_rst_seq
// Board-level reset sequencer: holds PCIe PERST_N low for PERST_CYC cycles,
// waits for DDR calibration (with timeout), releases the Ethernet PHY, waits
// PHY_DLY cycles, then releases the CPU core on a release pulse (or at once
// when AUTO_REL=1). A running CPU can be re-reset for at least CPU_HOLD cycles
// via cpu_hold_i; losing calibration while the CPU is up, or never getting it,
// parks the sequencer in FAULT until rst.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   fpga_rst_seq_if.slave (requests in, resets/fault/state out)
// -----------------------------------------------------------------------------
module fpga_rst_seq
    import fpga_rst_seq_pkg::*;
#(
    parameter int unsigned PERST_CYC = DEF_PERST_CYC,
    parameter int unsigned CALIB_TMO = DEF_CALIB_TMO,
    parameter int unsigned PHY_DLY   = DEF_PHY_DLY,
    parameter int unsigned CPU_HOLD  = DEF_CPU_HOLD,
    parameter bit          AUTO_REL  = DEF_AUTO_REL
) (
    input logic           clk,
    input logic           rst,
    fpga_rst_seq_if.slave bus
);

    localparam int unsigned CNT_MAX = max4(PERST_CYC, CALIB_TMO, PHY_DLY, CPU_HOLD);
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    logic             calib_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_load_s;
    rst_state_e       state_r;
    rst_state_e       state_nxt_s;

    logic             perst_n_nxt_s;
    logic             phy_rst_nxt_s;
    logic             cpu_rstn_nxt_s;
    logic             fault_nxt_s;
    logic             perst_n_r;
    logic             phy_rst_r;
    logic             cpu_rstn_r;
    logic             fault_r;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_calib_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.calib_done_i),
        .dout (calib_s)
    );

    // The counter is loaded with N-1 on state entry so the exit edge is the
    // N-th edge spent in the state.
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

    // next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PERST: begin
                if (cnt_zero_s) begin
                    state_nxt_s = CALIB;
                end else begin
                    state_nxt_s = PERST;
                end
            end
            CALIB: begin
                // calibration on the timeout edge still counts as success
                if (calib_s) begin
                    state_nxt_s = PHY;
                end else if (cnt_zero_s) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = CALIB;
                end
            end
            PHY: begin
                if (cnt_zero_s) begin
                    state_nxt_s = WREL;
                end else begin
                    state_nxt_s = PHY;
                end
            end
            WREL: begin
                // release pulses outside WREL are simply never looked at
                if (AUTO_REL || bus.cpu_rel_i) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WREL;
                end
            end
            RUN: begin
                // calibration loss outranks a simultaneous hold request
                if (!calib_s) begin
                    state_nxt_s = FAULT;
                end else if (bus.cpu_hold_i) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HOLD: begin
                if (!calib_s) begin
                    state_nxt_s = FAULT;
                end else if (cnt_zero_s && !bus.cpu_hold_i) begin
                    state_nxt_s = WREL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            FAULT: begin
                state_nxt_s = FAULT;
            end
            default: begin
                // unreachable encoding: restart the whole board sequence
                state_nxt_s = PERST;
            end
        endcase
    end

    // counter reload value for the state being entered
    always_comb begin
        cnt_load_s = {CNT_W{1'b0}};
        case (state_nxt_s)
            PERST:   cnt_load_s = CNT_W'(PERST_CYC - 32'd1);
            CALIB:   cnt_load_s = CNT_W'(CALIB_TMO - 32'd1);
            PHY:     cnt_load_s = CNT_W'(PHY_DLY - 32'd1);
            HOLD:    cnt_load_s = CNT_W'(CPU_HOLD - 32'd1);
            default: cnt_load_s = {CNT_W{1'b0}};
        endcase
    end

    // output decode from the next state so outputs move with the state
    always_comb begin
        perst_n_nxt_s  = 1'b0;
        phy_rst_nxt_s  = 1'b0;
        cpu_rstn_nxt_s = 1'b0;
        fault_nxt_s    = 1'b0;
        case (state_nxt_s)
            PERST: begin
                perst_n_nxt_s = 1'b0;
            end
            CALIB: begin
                perst_n_nxt_s = 1'b1;
            end
            PHY, WREL, HOLD: begin
                perst_n_nxt_s = 1'b1;
                phy_rst_nxt_s = 1'b1;
            end
            RUN: begin
                perst_n_nxt_s  = 1'b1;
                phy_rst_nxt_s  = 1'b1;
                cpu_rstn_nxt_s = 1'b1;
            end
            FAULT: begin
                perst_n_nxt_s = 1'b1;
                fault_nxt_s   = 1'b1;
            end
            default: begin
                perst_n_nxt_s = 1'b0;
            end
        endcase
    end

    // state, shared counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= PERST;
            cnt_r      <= CNT_W'(PERST_CYC - 32'd1);
            perst_n_r  <= 1'b0;
            phy_rst_r  <= 1'b0;
            cpu_rstn_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            perst_n_r  <= perst_n_nxt_s;
            phy_rst_r  <= phy_rst_nxt_s;
            cpu_rstn_r <= cpu_rstn_nxt_s;
            fault_r    <= fault_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= cnt_load_s;
            end else if (!cnt_zero_s) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.perst_n_o  = perst_n_r;
    assign bus.phy_rst_o  = phy_rst_r;
    assign bus.cpu_rstn_o = cpu_rstn_r;
    assign bus.fault_o    = fault_r;
    assign bus.state_o    = state_r;

endmodule
